// File: rtl/mem_ctrl_if.sv
// Request/response and byte-bus signal bundle for mem_ctrl.
// slave = the controller, master = the CPU requesters together with the memory.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_sext;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_sext, ls_addr, ls_wdata, mem_din,
        input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_sext, ls_addr, ls_wdata, mem_din,
        output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store ports onto an
// 8-bit bus with one-cycle read latency, freezing sequencing while rdy_in is low.
module mem_ctrl (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] addr_r, wdata_r, data_r, mem_a_r, if_data_r, ls_rdata_r;
    logic [7:0]  mem_dout_r;
    logic [2:0]  n_r, idx_r, cap_r;
    logic [1:0]  size_r;
    logic        sext_r, is_ls_r, pend_r, issued_r, wr_r, if_done_r, ls_done_r;

    logic        req_any_s, take_ls_s, take_we_s, read_last_s, write_last_s;
    logic [31:0] take_addr_s, data_cap_s;
    logic [2:0]  take_n_s, cap_cnt_s;

    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_ins(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] size,
                                             input logic sext);
        case (size)
            2'b00:   return sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            2'b01:   return sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign bus.mem_a    = mem_a_r;
    assign bus.mem_dout = mem_dout_r;
    // A paused cycle never writes, so each store byte lands exactly once.
    assign bus.mem_wr   = wr_r & rdy_in;
    assign bus.if_done  = if_done_r;
    assign bus.if_data  = if_data_r;
    assign bus.ls_done  = ls_done_r;
    assign bus.ls_rdata = ls_rdata_r;

    // Requester selection (load/store wins) and read-capture bookkeeping.
    always_comb begin
        req_any_s = bus.ls_req | bus.if_req;
        take_ls_s = bus.ls_req;
        if (bus.ls_req) begin
            take_we_s   = bus.ls_we;
            take_addr_s = bus.ls_addr;
            take_n_s    = size_to_n(bus.ls_size);
        end else begin
            take_we_s   = 1'b0;
            take_addr_s = bus.if_addr;
            take_n_s    = 3'd4;
        end
        if (issued_r) begin
            cap_cnt_s  = cap_r + 3'd1;
            data_cap_s = byte_ins(data_r, cap_r[1:0], bus.mem_din);
        end else begin
            cap_cnt_s  = cap_r;
            data_cap_s = data_r;
        end
        read_last_s  = (cap_cnt_s == n_r);
        write_last_s = (idx_r == n_r);
    end

    // Next-state logic; every transition waits for rdy_in.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rdy_in && req_any_s) state_nxt_s = take_we_s ? WRITE : READ;
                else                     state_nxt_s = IDLE;
            end
            READ: begin
                if (rdy_in && read_last_s) state_nxt_s = DONE;
                else                       state_nxt_s = READ;
            end
            WRITE: begin
                if (rdy_in && write_last_s) state_nxt_s = DONE;
                else                        state_nxt_s = WRITE;
            end
            DONE: begin
                if (rdy_in) state_nxt_s = IDLE;
                else        state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_r <= IDLE;
        else         state_r <= state_nxt_s;
    end

    // Datapath: operand latch, address/data sequencing, capture and done pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            data_r     <= 32'd0;
            mem_a_r    <= 32'd0;
            mem_dout_r <= 8'd0;
            if_data_r  <= 32'd0;
            ls_rdata_r <= 32'd0;
            n_r        <= 3'd0;
            idx_r      <= 3'd0;
            cap_r      <= 3'd0;
            size_r     <= 2'd0;
            sext_r     <= 1'b0;
            is_ls_r    <= 1'b0;
            pend_r     <= 1'b0;
            issued_r   <= 1'b0;
            wr_r       <= 1'b0;
            if_done_r  <= 1'b0;
            ls_done_r  <= 1'b0;
        end else begin
            // The byte for an address the bus already saw arrives even during a pause.
            if (issued_r) begin
                data_r <= data_cap_s;
                cap_r  <= cap_cnt_s;
            end
            if (!rdy_in) begin
                issued_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        issued_r <= 1'b0;
                        if (req_any_s) begin
                            addr_r  <= take_addr_s;
                            n_r     <= take_n_s;
                            size_r  <= bus.ls_size;
                            sext_r  <= bus.ls_sext;
                            wdata_r <= bus.ls_wdata;
                            is_ls_r <= take_ls_s;
                            mem_a_r <= take_addr_s;
                            wr_r    <= take_we_s;
                            pend_r  <= ~take_we_s;
                            idx_r   <= 3'd1;
                            cap_r   <= 3'd0;
                            data_r  <= 32'd0;
                            if (take_we_s) mem_dout_r <= byte_sel(bus.ls_wdata, 2'd0);
                        end
                    end
                    READ: begin
                        // pend_r: mem_a holds an address the bus has not consumed yet.
                        issued_r <= pend_r;
                        if (pend_r) begin
                            if (idx_r < n_r) begin
                                mem_a_r <= addr_r + {29'd0, idx_r};
                                idx_r   <= idx_r + 3'd1;
                            end else begin
                                pend_r <= 1'b0;
                            end
                        end
                        if (read_last_s) begin
                            if (is_ls_r) begin
                                ls_done_r  <= 1'b1;
                                ls_rdata_r <= load_ext(data_cap_s, size_r, sext_r);
                            end else begin
                                if_done_r <= 1'b1;
                                if_data_r <= data_cap_s;
                            end
                        end
                    end
                    WRITE: begin
                        if (!write_last_s) begin
                            mem_a_r    <= addr_r + {29'd0, idx_r};
                            mem_dout_r <= byte_sel(wdata_r, idx_r[1:0]);
                            idx_r      <= idx_r + 3'd1;
                        end else begin
                            wr_r      <= 1'b0;
                            ls_done_r <= 1'b1;
                        end
                    end
                    DONE: begin
                        if_done_r <= 1'b0;
                        ls_done_r <= 1'b0;
                    end
                    default: issued_r <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: requester tasks push expected responses into
// queues, a negedge monitor pops and compares them as done pulses appear.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with one-cycle read latency plus a preload port.
    logic [7:0]  mem [0:262143] = '{default: 8'h00};
    logic        pl_en = 1'b0;
    logic [17:0] pl_addr = 18'd0;
    logic [7:0]  pl_data = 8'd0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [7:0]  last_wd = 8'd0;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_wr === 1'b1) begin
            mem[bus.mem_a[17:0]] <= bus.mem_dout;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= bus.mem_a;
            last_wd <= bus.mem_dout;
        end
        bus.mem_din <= mem[bus.mem_a[17:0]];
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t q_if[$];
    exp_t q_ls[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic poke_w(input logic [17:0] a, input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            pl_addr = a + 18'(i);
            pl_data = t[7:0];
            pl_en   = 1'b1;
            @(posedge clk);
            #1;
            t = t >> 8;
        end
        pl_en = 1'b0;
    endtask

    task automatic ls_op(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int lat);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        bus.ls_we    = we;
        bus.ls_size  = size;
        bus.ls_sext  = sext;
        bus.ls_addr  = addr;
        bus.ls_wdata = wdata;
        bus.ls_req   = 1'b1;
        e.data = exp_data;
        e.cyc  = cyc + lat;
        q_ls.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.ls_done === 1'b1) seen = 1'b1;
        end
        check("ls_done_seen", {31'd0, seen}, 32'd1);
        bus.ls_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int lat);
        exp_t e;
        bit   seen;
        @(posedge clk);
        #1;
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        e.data = exp_data;
        e.cyc  = cyc + lat;
        q_if.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.if_done === 1'b1) seen = 1'b1;
        end
        check("if_done_seen", {31'd0, seen}, 32'd1);
        bus.if_req = 1'b0;
    endtask

    // rdy low for len cycles starting at cycle t0+from (t0 = next request cycle).
    task automatic rdy_gap(input int from, input int len);
        @(posedge clk);
        #1;
        repeat (from) @(posedge clk);
        #1;
        rdy = 1'b0;
        repeat (len) @(posedge clk);
        #1;
        rdy = 1'b1;
    endtask

    // Monitor: compare each done pulse against the scoreboard, watch mem_wr in pauses.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rdy === 1'b0)
                check("mem_wr_paused", {31'd0, bus.mem_wr}, 32'd0);
            if (bus.if_done === 1'b1) begin
                if (q_if.size() == 0) begin
                    check("if_done_unexpected", {31'd0, bus.if_done}, 32'd0);
                end else begin
                    e = q_if.pop_front();
                    check("if_data", bus.if_data, e.data);
                    check("if_cycle", cyc, e.cyc);
                end
            end
            if (bus.ls_done === 1'b1) begin
                if (q_ls.size() == 0) begin
                    check("ls_done_unexpected", {31'd0, bus.ls_done}, 32'd0);
                end else begin
                    e = q_ls.pop_front();
                    check("ls_rdata", bus.ls_rdata, e.data);
                    check("ls_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : stim
        int w0;
        bus.if_req = 1'b0;   bus.if_addr = 32'd0;
        bus.ls_req = 1'b0;   bus.ls_we = 1'b0;    bus.ls_size = 2'b00;
        bus.ls_sext = 1'b0;  bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;

        poke_w(18'h00100, 32'h00000513);
        poke_w(18'h00104, 32'h00100093);
        poke_w(18'h00200, 32'h12345678);
        poke_w(18'h00300, 32'h007FFF80);

        check("rst_if_done",  {31'd0, bus.if_done}, 32'd0);
        check("rst_ls_done",  {31'd0, bus.ls_done}, 32'd0);
        check("rst_if_data",  bus.if_data, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);
        check("rst_mem_a",    bus.mem_a, 32'd0);
        check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        check("rst_mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        w0 = wr_cnt;
        fetch(32'h100, 32'h00000513, 6);
        check("fetch_no_write", wr_cnt - w0, 32'd0);

        fork
            ls_op(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 32'h12345678, 6);
            fetch(32'h104, 32'h00100093, 13);
        join

        ls_op(1'b0, 2'b11, 1'b0, 32'h200, 32'd0, 32'h12345678, 6);
        ls_op(1'b0, 2'b01, 1'b1, 32'h300, 32'd0, 32'hFFFFFF80, 4);
        ls_op(1'b0, 2'b01, 1'b0, 32'h300, 32'd0, 32'h0000FF80, 4);
        ls_op(1'b0, 2'b01, 1'b1, 32'h301, 32'd0, 32'h00007FFF, 4);
        ls_op(1'b0, 2'b00, 1'b1, 32'h302, 32'd0, 32'h0000007F, 3);

        w0 = wr_cnt;
        fork
            ls_op(1'b1, 2'b00, 1'b0, 32'h30000, 32'hAABBCC41, 32'h0000007F, 5);
            rdy_gap(1, 3);
        join
        check("sb_write_count", wr_cnt - w0, 32'd1);
        check("sb_addr", last_wa, 32'h00030000);
        check("sb_data", {24'd0, last_wd}, 32'h41);
        check("sb_mem", {24'd0, mem[18'h30000]}, 32'h41);

        w0 = wr_cnt;
        ls_op(1'b1, 2'b01, 1'b0, 32'h2000, 32'h1234CAFE, 32'h0000007F, 3);
        check("sh_write_count", wr_cnt - w0, 32'd2);
        check("sh_mem0", {24'd0, mem[18'h02000]}, 32'hFE);
        check("sh_mem1", {24'd0, mem[18'h02001]}, 32'hCA);
        check("sh_mem2", {24'd0, mem[18'h02002]}, 32'h00);

        fork
            fetch(32'h100, 32'h00000513, 8);
            rdy_gap(3, 2);
        join

        // SW aborted by reset while byte 2 is on the bus.
        @(posedge clk);
        #1;
        bus.ls_we = 1'b1;  bus.ls_size = 2'b10; bus.ls_sext = 1'b0;
        bus.ls_addr = 32'h1000; bus.ls_wdata = 32'hDEADBEEF; bus.ls_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("sw_byte2_addr", bus.mem_a, 32'h00001002);
        rst_n = 1'b0;
        #1;
        check("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check("abort_mem_a",  bus.mem_a, 32'd0);
        check("abort_ls_done", {31'd0, bus.ls_done}, 32'd0);
        bus.ls_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_b0", {24'd0, mem[18'h01000]}, 32'hEF);
        check("abort_b1", {24'd0, mem[18'h01001]}, 32'hBE);
        check("abort_b2", {24'd0, mem[18'h01002]}, 32'h00);
        check("abort_b3", {24'd0, mem[18'h01003]}, 32'h00);
        ls_op(1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 32'h0000BEEF, 6);

        repeat (5) @(posedge clk);
        #1;
        check("q_if_empty", q_if.size(), 32'd0);
        check("q_ls_empty", q_ls.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
